// File: rtl/wei_fifo_pop_arbiter_pkg.sv
// Shared constants and helpers for the weight-FIFO read-side controller.
package wei_fifo_pop_arbiter_pkg;

  localparam int unsigned WEI_RD_NUM      = 27;
  localparam int unsigned WEI_DATA_WIDTH  = 64;
  localparam int unsigned WEI_POP_LATENCY = 1;
  localparam int unsigned WEI_OUT_DEPTH   = 2;

  // Ceiling log2, never below 1 so single-queue builds still get an id bit.
  function automatic int unsigned c_log_2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/wei_fifo_pop_arbiter_if.sv
// Request / FIFO-read / response bundle between the PE array, the weight FIFO
// and the pop arbiter. slave = arbiter side, master = environment side.
interface wei_fifo_pop_arbiter_if
  import wei_fifo_pop_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = WEI_DATA_WIDTH,
  parameter int unsigned RD_NUM     = WEI_RD_NUM,
  parameter int unsigned ID_WIDTH   = c_log_2(RD_NUM)
);
  logic [RD_NUM-1:0]     req;
  logic [RD_NUM-1:0]     fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  pop;
  logic [ID_WIDTH-1:0]   pop_id;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_WIDTH-1:0]   rsp_id;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport slave (
    input  req, fifo_empty, fifo_data, rsp_ready,
    output pop, pop_id, rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req, fifo_empty, fifo_data, rsp_ready,
    input  pop, pop_id, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/wei_fifo_pop_arbiter_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted id and wraps.
// The pointer only moves when the caller reports that the grant was used.
module wei_rr_arbiter
  import wei_fifo_pop_arbiter_pkg::*;
#(
  parameter int unsigned N = WEI_RD_NUM,
  parameter int unsigned W = c_log_2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic [N-1:0] eligible,
  input  logic         update,
  output logic         grant_valid,
  output logic [W-1:0] grant_id
);

  logic [W-1:0] pointer;
  logic         hi_found, lo_found;
  logic [W-1:0] hi_id, lo_id;

  // First eligible id above the pointer, else the lowest eligible id (wrap).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (eligible[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_id    = W'(i);
      end
      if (eligible[i] && !hi_found && (i > 32'(pointer))) begin
        hi_found = 1'b1;
        hi_id    = W'(i);
      end
    end
    grant_valid = |eligible;
    grant_id    = hi_found ? hi_id : lo_id;
  end

  // Pointer starts at the last id so id 0 has first priority after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pointer <= W'(N - 1);
    else if (clear)
      pointer <= W'(N - 1);
    else if (update && grant_valid)
      pointer <= grant_id;
  end

endmodule

// File: rtl/wei_fifo_pop_arbiter.sv
// Read-side controller for the multi-queue weight FIFO: collects per-PE
// requests, arbitrates one pop per cycle, absorbs the SRAM read latency and
// returns tagged words through a 2-entry response buffer.
// Optional statistics counters: define WEI_POP_STAT_EN.
module wei_fifo_pop_arbiter
  import wei_fifo_pop_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = WEI_DATA_WIDTH,
  parameter int unsigned RD_NUM     = WEI_RD_NUM,
  parameter int unsigned ID_WIDTH   = c_log_2(RD_NUM)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         Reset,
  wei_fifo_pop_arbiter_if.slave        bus
`ifdef WEI_POP_STAT_EN
  ,
  output logic [31:0]                  stall_cnt,
  output logic [31:0]                  bp_cnt
`endif
);

  logic [RD_NUM-1:0]     pending;
  logic [RD_NUM-1:0]     eligible;
  logic [RD_NUM-1:0]     grant_mask;
  logic                  grant_valid;
  logic [ID_WIDTH-1:0]   grant_id;
  logic                  issue;
  logic                  deq;
  logic [1:0]            occupancy;

  logic                  inflight;
  logic [ID_WIDTH-1:0]   inflight_id;

  logic [ID_WIDTH-1:0]   buf_id   [WEI_OUT_DEPTH];
  logic [DATA_WIDTH-1:0] buf_data [WEI_OUT_DEPTH];
  logic                  rd_sel, wr_sel;
  logic [1:0]            out_count;

  assign eligible  = pending & ~bus.fifo_empty;
  assign deq       = bus.rsp_valid && bus.rsp_ready;
  assign occupancy = out_count + {1'b0, inflight};

  wei_rr_arbiter #(.N(RD_NUM), .W(ID_WIDTH)) u_rr (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (Reset),
    .eligible    (eligible),
    .update      (issue),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Issue only if the word landing in two cycles has a buffer slot; a full
  // buffer still accepts when its head is leaving this same cycle.
  always_comb begin
    issue      = grant_valid && ((occupancy < 2'd2) || ((occupancy == 2'd2) && deq));
    grant_mask = '0;
    if (issue) grant_mask[grant_id] = 1'b1;
  end

  assign bus.pop    = issue;
  assign bus.pop_id = issue ? grant_id : '0;

  // Pending requests: grant clears, a same-cycle request re-arms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pending <= '0;
    else if (Reset)  pending <= '0;
    else             pending <= (pending & ~grant_mask) | bus.req;
  end

  // Tag of the SRAM read currently in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight    <= 1'b0;
      inflight_id <= '0;
    end else if (Reset) begin
      inflight    <= 1'b0;
      inflight_id <= '0;
    end else begin
      inflight <= issue;
      if (issue) inflight_id <= grant_id;
    end
  end

  // Two-entry response buffer, written with the SRAM word the cycle after pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < WEI_OUT_DEPTH; i++) begin
        buf_id[i]   <= '0;
        buf_data[i] <= '0;
      end
      rd_sel    <= 1'b0;
      wr_sel    <= 1'b0;
      out_count <= '0;
    end else if (Reset) begin
      for (int unsigned i = 0; i < WEI_OUT_DEPTH; i++) begin
        buf_id[i]   <= '0;
        buf_data[i] <= '0;
      end
      rd_sel    <= 1'b0;
      wr_sel    <= 1'b0;
      out_count <= '0;
    end else begin
      if (inflight) begin
        buf_id[wr_sel]   <= inflight_id;
        buf_data[wr_sel] <= bus.fifo_data;
        wr_sel           <= ~wr_sel;
      end
      if (deq) rd_sel <= ~rd_sel;
      out_count <= out_count + {1'b0, inflight} - {1'b0, deq};
    end
  end

  assign bus.rsp_valid = (out_count != 2'd0);
  assign bus.rsp_id    = buf_id[rd_sel];
  assign bus.rsp_data  = buf_data[rd_sel];

`ifdef WEI_POP_STAT_EN
  // Saturating counters for empty-queue stalls and buffer backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      bp_cnt    <= '0;
    end else if (Reset) begin
      stall_cnt <= '0;
      bp_cnt    <= '0;
    end else begin
      if ((|(pending & bus.fifo_empty)) && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if ((|eligible) && !issue && (bp_cnt != '1))            bp_cnt    <= bp_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wei_fifo_pop_arbiter.sv
// Directed bench for wei_fifo_pop_arbiter with a one-cycle-latency FIFO model.
module tb_wei_fifo_pop_arbiter;

  localparam int unsigned DW  = 64;
  localparam int unsigned RN  = 27;
  localparam int unsigned IDW = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Reset;
  logic [15:0] gen;
  int          vectors = 0;
  int          errs    = 0;

  int rr_pop[11] = '{-1, 0, 3, 26, -1, 0, 3, 26, -1, -1, -1};
  int rr_rsp[11] = '{-1, -1, -1, 0, 3, 26, -1, 0, 3, 26, -1};
  int bp_pop[12] = '{-1, 10, 11, -1, -1, -1, -1, 12, 13, -1, -1, -1};
  int bp_rsp[12] = '{-1, -1, -1, 10, 10, 10, 10, 10, 11, 12, 13, -1};

  wei_fifo_pop_arbiter_if #(.DATA_WIDTH(DW), .RD_NUM(RN), .ID_WIDTH(IDW)) bus ();

`ifdef WEI_POP_STAT_EN
  logic [31:0] stall_cnt, bp_cnt;
`endif

  wei_fifo_pop_arbiter #(.DATA_WIDTH(DW), .RD_NUM(RN), .ID_WIDTH(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Reset (Reset),
    .bus   (bus)
`ifdef WEI_POP_STAT_EN
    ,
    .stall_cnt (stall_cnt),
    .bp_cnt    (bp_cnt)
`endif
  );

  always #5 clk = ~clk;

  // SRAM model: word tagged with test generation and queue id, one cycle after pop.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       bus.fifo_data <= '0;
    else if (bus.pop) bus.fifo_data <= {32'hC0DE_0000, gen, 11'd0, bus.pop_id};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ep/er < 0 means no pop / no response expected in this cycle.
  task automatic chk_cycle(input string tag, input int ep, input int er);
    if (ep < 0) begin
      check({tag, ".pop"}, 64'(bus.pop), 64'd0);
    end else begin
      check({tag, ".pop"}, 64'(bus.pop), 64'd1);
      check({tag, ".pop_id"}, 64'(bus.pop_id), 64'(ep));
    end
    if (er < 0) begin
      check({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    end else begin
      check({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
      check({tag, ".rsp_id"}, 64'(bus.rsp_id), 64'(er));
      check({tag, ".rsp_data"}, bus.rsp_data, {32'hC0DE_0000, gen, 11'd0, 5'(er)});
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic step(input logic [RN-1:0] r);
    nxt();
    bus.req = r;
    settle();
  endtask

  initial begin
    rst_n          = 1'b0;
    Reset          = 1'b0;
    bus.req        = '0;
    bus.fifo_empty = '0;
    bus.rsp_ready  = 1'b1;
    gen            = 16'd1;
    #12;
    check("rst.pop",       64'(bus.pop),       64'd0);
    check("rst.pop_id",    64'(bus.pop_id),    64'd0);
    check("rst.rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst.rsp_id",    64'(bus.rsp_id),    64'd0);
    check("rst.rsp_data",  bus.rsp_data,       64'd0);
    rst_n = 1'b1;

    // Single request: pop at +1, response at +3.
    step(27'd1 << 5);  chk_cycle("single0", -1, -1);
    step('0);          chk_cycle("single1", 5, -1);
    step('0);          chk_cycle("single2", -1, -1);
    step('0);          chk_cycle("single3", -1, 5);
    step('0);          chk_cycle("single4", -1, -1);

    // Synchronous clear returns the pointer to 26, then round-robin order.
    gen = 16'd2;
    nxt(); Reset = 1'b1;
    nxt(); Reset = 1'b0;
    for (int k = 0; k < 11; k++) begin
      step((k == 0 || k == 4) ? ((27'd1 << 0) | (27'd1 << 3) | (27'd1 << 26)) : '0);
      chk_cycle($sformatf("rr%0d", k), rr_pop[k], rr_rsp[k]);
    end

    // Pending PE with empty queue waits, then pops the cycle empty falls.
    gen = 16'd3;
    bus.fifo_empty = 27'd1 << 7;
    step(27'd1 << 7);  chk_cycle("empty_req", -1, -1);
    for (int k = 0; k < 10; k++) begin
      step('0);        chk_cycle($sformatf("empty_wait%0d", k), -1, -1);
    end
    nxt(); bus.fifo_empty = '0; bus.req = '0; settle();
    chk_cycle("empty_pop", 7, -1);
    step('0);          chk_cycle("empty_p1", -1, -1);
    step('0);          chk_cycle("empty_rsp", -1, 7);
    step('0);          chk_cycle("empty_done", -1, -1);

    // Backpressure: two pops fill the buffer, rest follow after ready.
    gen = 16'd4;
    for (int k = 0; k < 12; k++) begin
      nxt();
      bus.req       = (k == 0) ? ((27'd1 << 10) | (27'd1 << 11) | (27'd1 << 12) | (27'd1 << 13)) : '0;
      bus.rsp_ready = (k >= 7);
      settle();
      chk_cycle($sformatf("bp%0d", k), bp_pop[k], bp_rsp[k]);
    end

    // Re-request in the grant cycle yields a second word.
    gen = 16'd5;
    step(27'd1 << 2);  chk_cycle("rereq0", -1, -1);
    step(27'd1 << 2);  chk_cycle("rereq1", 2, -1);
    step('0);          chk_cycle("rereq2", 2, -1);
    step('0);          chk_cycle("rereq3", -1, 2);
    step('0);          chk_cycle("rereq4", -1, 2);
    step('0);          chk_cycle("rereq5", -1, -1);

    // Duplicate request while pending collapses into one.
    bus.fifo_empty = 27'd1 << 2;
    step(27'd1 << 2);  chk_cycle("dup0", -1, -1);
    step('0);          chk_cycle("dup1", -1, -1);
    step(27'd1 << 2);  chk_cycle("dup2", -1, -1);
    step('0);          chk_cycle("dup3", -1, -1);
    nxt(); bus.fifo_empty = '0; bus.req = '0; settle();
    chk_cycle("dup4", 2, -1);
    step('0);          chk_cycle("dup5", -1, -1);
    step('0);          chk_cycle("dup6", -1, 2);
    step('0);          chk_cycle("dup7", -1, -1);
    step('0);          chk_cycle("dup8", -1, -1);

    // Clear the cycle after a pop: the read is dropped, pointer back to 26.
    gen = 16'd6;
    step(27'd1 << 20); chk_cycle("mid0", -1, -1);
    step('0);          chk_cycle("mid1", 20, -1);
    nxt(); Reset = 1'b1; settle();
    chk_cycle("mid2", -1, -1);
    nxt(); Reset = 1'b0; settle();
    chk_cycle("mid3", -1, -1);
    step('0);          chk_cycle("mid4", -1, -1);
    step((27'd1 << 1) | (27'd1 << 25)); chk_cycle("mid5", -1, -1);
    step('0);          chk_cycle("mid6", 1, -1);
    step('0);          chk_cycle("mid7", 25, -1);
    step('0);          chk_cycle("mid8", -1, 1);
    step('0);          chk_cycle("mid9", -1, 25);
    step('0);          chk_cycle("mid10", -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
